uart_cmd_bridge: RTL and testbench
==================================

UART_CMD_BRIDGE -- requirements
Module: uart_cmd_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT, default 100000, meaning the cycle limit for both inter-byte gaps and bus acknowledge waits.
REQ-002 SHALL have CLK_I, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have RESET_N_I, input, 1, asynchronous active-low reset.
REQ-004 SHALL have RX_DATA_I, input, 8, received byte from the UART.
REQ-005 SHALL have RX_VALID_I, input, 1, one-cycle pulse marking RX_DATA_I valid.
REQ-006 SHALL have RX_ERROR_I, input, 1, one-cycle pulse marking a UART framing error.
REQ-007 SHALL have TX_DATA_O, output, 8, byte to transmit.
REQ-008 SHALL have TX_VALID_O, output, 1, one-cycle transmit request.
REQ-009 SHALL have TX_BUSY_I, input, 1, UART transmitter busy.
REQ-010 SHALL have BUS_ADDR_O, output, 8, register address.
REQ-011 SHALL have BUS_WDATA_O, output, 32, write data.
REQ-012 SHALL have BUS_WE_O and BUS_RE_O, outputs, 1 each, write and read requests, held until acknowledged.
REQ-013 SHALL have BUS_RDATA_I, input, 32, read data, sampled on BUS_ACK_I.
REQ-014 SHALL have BUS_ACK_I, input, 1, one-cycle bus acknowledge.
REQ-015 SHALL have BUSY_O, output, 1, high whenever the state is not IDLE.

Function
REQ-016 Frame formats SHALL be:
- write: 0x57, addr, d[31:24], d[23:16], d[15:8], d[7:0]; reply 0x4B.
- read: 0x52, addr; reply four bytes of read data, MSB first.
REQ-017 States SHALL be IDLE, ADDR, WDATA, BUS, REPLY.
REQ-018 IDLE transitions on an RX_VALID_I byte SHALL be:
- 0x57 or 0x52: latch the command, go to ADDR.
- any other value: load reply 0x3F, go to REPLY.
REQ-019 ADDR SHALL latch the byte into BUS_ADDR_O, then go to WDATA for a write or BUS for a read.
REQ-020 WDATA SHALL shift 4 bytes into BUS_WDATA_O, MSB first, using a 2-bit byte counter, then go to BUS.
REQ-021 BUS SHALL assert BUS_WE_O or BUS_RE_O from the first cycle in BUS until the cycle BUS_ACK_I is sampled high; both SHALL never be high together.
REQ-022 On BUS_ACK_I, the bridge SHALL deassert the request on the next edge, capture BUS_RDATA_I for a read, and go to REPLY.
REQ-023 REPLY SHALL send 1 byte (write, error, unknown) or 4 bytes (read).
REQ-024 TX handshake SHALL be:
- pulse TX_VALID_O for exactly 1 cycle with TX_DATA_O stable, only when TX_BUSY_I is 0;
- after a pulse, do not pulse again until TX_BUSY_I has been seen 1 and then 0.
REQ-025 After the last reply byte's handshake completes (TX_BUSY_I back to 0), the state SHALL return to IDLE.
REQ-026 A timeout counter SHALL clear on every accepted byte and on entry to BUS, and SHALL count in ADDR, WDATA and BUS.
REQ-027 Timeout in ADDR or WDATA SHALL return to IDLE silently, with no bus access and no reply.
REQ-028 Timeout in BUS (TIMEOUT cycles without BUS_ACK_I) SHALL drop the request and send reply 0x45; a late BUS_ACK_I SHALL be ignored.
REQ-029 RX_ERROR_I in IDLE, ADDR or WDATA SHALL abort the frame to IDLE with no reply; if RX_ERROR_I and RX_VALID_I occur in the same cycle, the error wins.
REQ-030 RX_VALID_I bytes arriving in BUS or REPLY SHALL be discarded without affecting state.
REQ-031 BUS_ACK_I outside BUS SHALL be ignored.
REQ-032 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and saturate; it SHALL never wrap.

Reset
REQ-033 Reset assertion SHALL immediately force:
- state IDLE;
- TX_VALID_O, BUS_WE_O, BUS_RE_O, BUSY_O = 0;
- TX_DATA_O = 0x00, BUS_ADDR_O = 0x00, BUS_WDATA_O = 0;
- counters = 0.
REQ-034 Reset mid-frame or mid-bus-access SHALL abandon the transaction; no request or reply SHALL appear after release.
REQ-035 The first RX_VALID_I SHALL be acted on no earlier than the first clock edge after RESET_N_I deasserts.

Verification
REQ-036 Write: bytes 57 10 DE AD BE EF, ACK after 3 cycles -> BUS_WE_O with addr 0x10, data 0xDEADBEEF, held 3 cycles; then reply 0x4B.
REQ-037 Read: bytes 52 20, BUS_RDATA_I = 0x12345678 on ACK -> TX bytes 12 34 56 78, each sent only after TX_BUSY_I falls.
REQ-038 Unknown/error: byte 0x41 -> reply 0x3F; bytes 57 10 AA then RX_ERROR_I -> IDLE, no bus access, no reply.
REQ-039 Timeouts (TIMEOUT=16):
- 52 then a 17-cycle gap -> IDLE silently;
- read with no ACK -> BUS_RE_O high 16 cycles, then reply 0x45.
REQ-040 Reset during BUS with BUS_RE_O high -> BUS_RE_O low asynchronously; no TX_VALID_O after release; BUSY_O = 0.

Source files
------------

// File: rtl/uart_cmd_bridge.sv
// Purpose : turns UART command frames (write 0x57 / read 0x52) into single register-bus accesses and replies over UART.
// Latency : bus request rises one cycle after the last frame byte; first reply byte one cycle after ack (if TX idle).
// Backpress: reply bytes wait for TX_BUSY_I low and a full busy 1->0 handshake; RX bytes in BUS/REPLY are dropped.
//
// Ports:
//   CLK_I, RESET_N_I                  clock, asynchronous active-low reset
//   RX_DATA_I/RX_VALID_I/RX_ERROR_I   received byte stream from the UART receiver
//   TX_DATA_O/TX_VALID_O/TX_BUSY_I    reply byte stream to the UART transmitter
//   BUS_*                             register bus: address, write data, we/re held until BUS_ACK_I
//   BUSY_O                            high whenever a frame is in progress
module uart_cmd_bridge #(
    parameter int TIMEOUT = 100000
) (
    input  logic        CLK_I,
    input  logic        RESET_N_I,
    input  logic [7:0]  RX_DATA_I,
    input  logic        RX_VALID_I,
    input  logic        RX_ERROR_I,
    output logic [7:0]  TX_DATA_O,
    output logic        TX_VALID_O,
    input  logic        TX_BUSY_I,
    output logic [7:0]  BUS_ADDR_O,
    output logic [31:0] BUS_WDATA_O,
    output logic        BUS_WE_O,
    output logic        BUS_RE_O,
    input  logic [31:0] BUS_RDATA_I,
    input  logic        BUS_ACK_I,
    output logic        BUSY_O
);

    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_MAX  = TW'(TIMEOUT);

    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;
    localparam logic [7:0] RPL_OK  = 8'h4B;
    localparam logic [7:0] RPL_UNK = 8'h3F;
    localparam logic [7:0] RPL_TMO = 8'h45;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WDATA, S_BUS, S_REPLY} state_t;
    typedef enum logic [1:0] {TX_SEND, TX_WAIT_HI, TX_WAIT_LO} tx_phase_t;

    state_t         state;
    tx_phase_t      tx_phase;
    logic           is_write;
    logic [1:0]     byte_cnt;
    logic [1:0]     reply_left;   // reply bytes still to go after the one in reply_buf[31:24]
    logic [31:0]    reply_buf;
    logic [TW-1:0]  tmo_cnt;
    logic [TW-1:0]  tmo_inc;
    logic           tmo_hit;

    // Saturating increment: the counter never wraps even if left counting.
    assign tmo_inc = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
    // The cycle in which the count reaches TIMEOUT-1 is the TIMEOUT-th cycle spent waiting.
    assign tmo_hit = (tmo_cnt >= TMO_LAST);
    assign BUSY_O  = (state != S_IDLE);

    always_ff @(posedge CLK_I or negedge RESET_N_I) begin
        if (!RESET_N_I) begin
            state       <= S_IDLE;
            tx_phase    <= TX_SEND;
            is_write    <= 1'b0;
            byte_cnt    <= 2'd0;
            reply_left  <= 2'd0;
            reply_buf   <= 32'h0;
            tmo_cnt     <= '0;
            TX_DATA_O   <= 8'h00;
            TX_VALID_O  <= 1'b0;
            BUS_ADDR_O  <= 8'h00;
            BUS_WDATA_O <= 32'h0;
            BUS_WE_O    <= 1'b0;
            BUS_RE_O    <= 1'b0;
        end else begin
            TX_VALID_O <= 1'b0;
            case (state)
                S_IDLE: begin
                    tmo_cnt <= '0;
                    // A framing error in the same cycle as a byte discards the byte.
                    if (RX_VALID_I && !RX_ERROR_I) begin
                        if (RX_DATA_I == CMD_WR || RX_DATA_I == CMD_RD) begin
                            is_write <= (RX_DATA_I == CMD_WR);
                            state    <= S_ADDR;
                        end else begin
                            reply_buf  <= {RPL_UNK, 24'h0};
                            reply_left <= 2'd0;
                            tx_phase   <= TX_SEND;
                            state      <= S_REPLY;
                        end
                    end
                end
                S_ADDR: begin
                    if (RX_ERROR_I) begin
                        state <= S_IDLE;
                    end else if (RX_VALID_I) begin
                        BUS_ADDR_O <= RX_DATA_I;
                        tmo_cnt    <= '0;
                        if (is_write) begin
                            byte_cnt <= 2'd0;
                            state    <= S_WDATA;
                        end else begin
                            BUS_RE_O <= 1'b1;
                            state    <= S_BUS;
                        end
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                S_WDATA: begin
                    if (RX_ERROR_I) begin
                        state <= S_IDLE;
                    end else if (RX_VALID_I) begin
                        BUS_WDATA_O <= {BUS_WDATA_O[23:0], RX_DATA_I};
                        byte_cnt    <= byte_cnt + 2'd1;
                        tmo_cnt     <= '0;
                        if (byte_cnt == 2'd3) begin
                            BUS_WE_O <= 1'b1;
                            state    <= S_BUS;
                        end
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                S_BUS: begin
                    if (BUS_ACK_I) begin
                        BUS_WE_O   <= 1'b0;
                        BUS_RE_O   <= 1'b0;
                        reply_buf  <= is_write ? {RPL_OK, 24'h0} : BUS_RDATA_I;
                        reply_left <= is_write ? 2'd0 : 2'd3;
                        tx_phase   <= TX_SEND;
                        state      <= S_REPLY;
                    end else if (tmo_hit) begin
                        BUS_WE_O   <= 1'b0;
                        BUS_RE_O   <= 1'b0;
                        reply_buf  <= {RPL_TMO, 24'h0};
                        reply_left <= 2'd0;
                        tx_phase   <= TX_SEND;
                        state      <= S_REPLY;
                    end else begin
                        tmo_cnt <= tmo_inc;
                    end
                end
                S_REPLY: begin
                    case (tx_phase)
                        TX_SEND: begin
                            if (!TX_BUSY_I) begin
                                TX_VALID_O <= 1'b1;
                                TX_DATA_O  <= reply_buf[31:24];
                                tx_phase   <= TX_WAIT_HI;
                            end
                        end
                        // The transmitter must be seen to accept (busy high) before
                        // its release (busy low) counts as completion of this byte.
                        TX_WAIT_HI: begin
                            if (TX_BUSY_I) tx_phase <= TX_WAIT_LO;
                        end
                        TX_WAIT_LO: begin
                            if (!TX_BUSY_I) begin
                                if (reply_left == 2'd0) begin
                                    state <= S_IDLE;
                                end else begin
                                    reply_left <= reply_left - 2'd1;
                                    reply_buf  <= {reply_buf[23:0], 8'h00};
                                    tx_phase   <= TX_SEND;
                                end
                            end
                        end
                        default: tx_phase <= TX_SEND;
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_cmd_bridge.sv
// Purpose : self-checking bench for uart_cmd_bridge with a frame-level reference model and scoreboard.
// Latency : n/a (bench).
// Backpress: TX responder holds TX_BUSY_I for several cycles per byte; bus responder acks after a programmable delay.
module tb_uart_cmd_bridge;

    localparam int TMO = 16;

    logic        CLK_I = 1'b0;
    logic        RESET_N_I;
    logic [7:0]  RX_DATA_I;
    logic        RX_VALID_I;
    logic        RX_ERROR_I;
    logic [7:0]  TX_DATA_O;
    logic        TX_VALID_O;
    logic        TX_BUSY_I;
    logic [7:0]  BUS_ADDR_O;
    logic [31:0] BUS_WDATA_O;
    logic        BUS_WE_O;
    logic        BUS_RE_O;
    logic [31:0] BUS_RDATA_I;
    logic        BUS_ACK_I;
    logic        BUSY_O;

    uart_cmd_bridge #(.TIMEOUT(TMO)) dut (
        .CLK_I(CLK_I), .RESET_N_I(RESET_N_I),
        .RX_DATA_I(RX_DATA_I), .RX_VALID_I(RX_VALID_I), .RX_ERROR_I(RX_ERROR_I),
        .TX_DATA_O(TX_DATA_O), .TX_VALID_O(TX_VALID_O), .TX_BUSY_I(TX_BUSY_I),
        .BUS_ADDR_O(BUS_ADDR_O), .BUS_WDATA_O(BUS_WDATA_O),
        .BUS_WE_O(BUS_WE_O), .BUS_RE_O(BUS_RE_O),
        .BUS_RDATA_I(BUS_RDATA_I), .BUS_ACK_I(BUS_ACK_I), .BUSY_O(BUSY_O)
    );

    initial forever #5 CLK_I = ~CLK_I;

    typedef struct {
        bit          we;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          len;
    } bus_t;

    bus_t        exp_bus[$];
    logic [7:0]  exp_tx[$];
    logic [7:0]  tx_log[$];

    int          checks = 0;
    int          errors = 0;
    int          ack_delay = 0;
    logic [31:0] rdata_val = 32'h0;
    int          bus_rises = 0;
    int          last_len = 0;
    bit          last_we = 1'b0;
    logic [7:0]  last_addr = 8'h00;
    logic [31:0] last_wdata = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Frame-level reference: what bus access and reply bytes a complete frame must produce.
    // fr holds n bytes right-aligned, first byte most significant.
    task automatic model_frame(input logic [47:0] fr, input int n, input bit aborted,
                               input int ackd, input logic [31:0] rd);
        bus_t       e;
        logic [7:0] cmd;
        int         need;
        if (aborted || n == 0) return;
        cmd = fr[8*(n-1) +: 8];
        if (cmd != 8'h57 && cmd != 8'h52) begin
            exp_tx.push_back(8'h3F);
            return;
        end
        need = (cmd == 8'h57) ? 6 : 2;
        if (n < need) return;              // incomplete frame times out silently
        e.we    = (cmd == 8'h57);
        e.addr  = fr[8*(n-2) +: 8];
        e.wdata = e.we ? fr[31:0] : 32'h0;
        e.len   = (ackd == 0) ? TMO : ackd;
        exp_bus.push_back(e);
        if (ackd == 0)      exp_tx.push_back(8'h45);
        else if (e.we)      exp_tx.push_back(8'h4B);
        else for (int i = 3; i >= 0; i--) exp_tx.push_back(rd[8*i +: 8]);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit vld, input bit err);
        @(negedge CLK_I);
        RX_DATA_I  = b;
        RX_VALID_I = vld;
        RX_ERROR_I = err;
        @(negedge CLK_I);
        RX_VALID_I = 1'b0;
        RX_ERROR_I = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (BUSY_O && n < 400) begin
            @(negedge CLK_I);
            n++;
        end
        chk("wait_idle_busy", 32'(BUSY_O), 32'h0);
    endtask

    task automatic run_frame(input logic [47:0] fr, input int n, input int ackd,
                             input logic [31:0] rd, input logic [7:0] stray);
        tx_log.delete();
        ack_delay = ackd;
        rdata_val = rd;
        model_frame(fr, n, 1'b0, ackd, rd);
        for (int i = 0; i < n; i++) send_byte(fr[8*(n-1-i) +: 8], 1'b1, 1'b0);
        if (stray != 8'h00) send_byte(stray, 1'b1, 1'b0);
        wait_idle();
        chk("exp_bus_drained", 32'(exp_bus.size()), 32'h0);
        chk("exp_tx_drained", 32'(exp_tx.size()), 32'h0);
    endtask

    // UART transmitter stand-in: busy rises one cycle late (the bridge must not
    // re-send in that window) and stays high three cycles.
    initial begin
        TX_BUSY_I = 1'b0;
        forever begin
            @(negedge CLK_I);
            if (TX_VALID_O && RESET_N_I) begin
                @(negedge CLK_I);
                #1 TX_BUSY_I = 1'b1;
                repeat (3) @(negedge CLK_I);
                #1 TX_BUSY_I = 1'b0;
            end
        end
    end

    // Bus target stand-in: acks in the ack_delay-th request cycle; with ack_delay 0
    // it never acks in time and instead pulses a late ack right after the request drops.
    initial begin
        int cyc = 0;
        bit req, prev_req = 1'b0;
        BUS_ACK_I   = 1'b0;
        BUS_RDATA_I = 32'h0;
        forever begin
            @(negedge CLK_I);
            #1;
            req = BUS_WE_O | BUS_RE_O;
            if (req) begin
                cyc++;
                if (ack_delay != 0 && cyc == ack_delay) begin
                    BUS_ACK_I   = 1'b1;
                    BUS_RDATA_I = rdata_val;
                end else begin
                    BUS_ACK_I = 1'b0;
                end
            end else begin
                BUS_ACK_I = prev_req && (ack_delay == 0);
                cyc = 0;
            end
            prev_req = req;
        end
    end

    // Compare process: checks every cycle against the scoreboard filled by the model.
    initial begin
        bit   req_open = 1'b0;
        int   req_len = 0;
        bit   tx_wait = 1'b0;
        bit   tx_saw_busy = 1'b0;
        bit   have_cur = 1'b0;
        bus_t cur;
        forever begin
            @(negedge CLK_I);
            if (!RESET_N_I) begin
                req_open = 1'b0;
                req_len  = 0;
                tx_wait  = 1'b0;
                have_cur = 1'b0;
            end else begin
                chk("we_re_exclusive", 32'(BUS_WE_O & BUS_RE_O), 32'h0);
                if (BUS_WE_O || BUS_RE_O) begin
                    if (!req_open) begin
                        req_open   = 1'b1;
                        req_len    = 1;
                        bus_rises++;
                        last_we    = BUS_WE_O;
                        last_addr  = BUS_ADDR_O;
                        last_wdata = BUS_WDATA_O;
                        if (exp_bus.size() == 0) begin
                            chk("unexpected_bus_req", 32'h1, 32'h0);
                            have_cur = 1'b0;
                        end else begin
                            cur = exp_bus.pop_front();
                            have_cur = 1'b1;
                            chk("bus_we", 32'(BUS_WE_O), 32'(cur.we));
                            chk("bus_re", 32'(BUS_RE_O), 32'(!cur.we));
                            chk("bus_addr", 32'(BUS_ADDR_O), 32'(cur.addr));
                            if (cur.we) chk("bus_wdata", BUS_WDATA_O, cur.wdata);
                        end
                    end else begin
                        req_len++;
                    end
                end else if (req_open) begin
                    req_open = 1'b0;
                    last_len = req_len;
                    if (have_cur) chk("bus_req_cycles", 32'(req_len), 32'(cur.len));
                    have_cur = 1'b0;
                end
                if (TX_VALID_O) begin
                    chk("tx_pulse_allowed", {30'h0, TX_BUSY_I, tx_wait}, 32'h0);
                    tx_wait     = 1'b1;
                    tx_saw_busy = 1'b0;
                    tx_log.push_back(TX_DATA_O);
                    if (exp_tx.size() == 0) chk("unexpected_tx", 32'(TX_DATA_O), 32'hFFFF_FFFF);
                    else chk("tx_data", 32'(TX_DATA_O), 32'(exp_tx.pop_front()));
                end else if (tx_wait) begin
                    if (TX_BUSY_I) tx_saw_busy = 1'b1;
                    else if (tx_saw_busy) tx_wait = 1'b0;
                end
            end
        end
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int rises0;
        RESET_N_I  = 1'b0;
        RX_DATA_I  = 8'h00;
        RX_VALID_I = 1'b0;
        RX_ERROR_I = 1'b0;
        repeat (3) @(negedge CLK_I);

        chk("rst_tx_valid", 32'(TX_VALID_O), 32'h0);
        chk("rst_tx_data", 32'(TX_DATA_O), 32'h0);
        chk("rst_we", 32'(BUS_WE_O), 32'h0);
        chk("rst_re", 32'(BUS_RE_O), 32'h0);
        chk("rst_busy", 32'(BUSY_O), 32'h0);
        chk("rst_addr", 32'(BUS_ADDR_O), 32'h0);
        chk("rst_wdata", BUS_WDATA_O, 32'h0);
        #2 RESET_N_I = 1'b1;
        repeat (2) @(negedge CLK_I);

        // Write, ack in the third request cycle.
        run_frame(48'h57_10_DE_AD_BE_EF, 6, 3, 32'h0, 8'h00);
        chk("wr_is_write", 32'(last_we), 32'h1);
        chk("wr_addr", 32'(last_addr), 32'h10);
        chk("wr_wdata", last_wdata, 32'hDEADBEEF);
        chk("wr_len", 32'(last_len), 32'd3);
        chk("wr_reply_count", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() == 1) chk("wr_reply", 32'(tx_log[0]), 32'h4B);

        // Read returns four bytes, MSB first.
        run_frame(48'h52_20, 2, 2, 32'h12345678, 8'h00);
        chk("rd_is_read", 32'(last_we), 32'h0);
        chk("rd_addr", 32'(last_addr), 32'h20);
        chk("rd_reply_count", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() == 4)
            chk("rd_reply", {tx_log[0], tx_log[1], tx_log[2], tx_log[3]}, 32'h12345678);

        // Unknown command byte.
        run_frame(48'h41, 1, 1, 32'h0, 8'h00);
        chk("unk_reply_count", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() == 1) chk("unk_reply", 32'(tx_log[0]), 32'h3F);

        // Stray byte arriving during BUS is dropped.
        run_frame(48'h57_11_01_02_03_04, 6, 6, 32'h0, 8'h41);
        chk("stray_wdata", last_wdata, 32'h01020304);
        chk("stray_reply_count", 32'(tx_log.size()), 32'd1);

        // Framing error mid-write aborts silently.
        tx_log.delete();
        rises0 = bus_rises;
        model_frame(48'h57_10_AA, 3, 1'b1, 1, 32'h0);
        send_byte(8'h57, 1'b1, 1'b0);
        send_byte(8'h10, 1'b1, 1'b0);
        send_byte(8'hAA, 1'b1, 1'b0);
        send_byte(8'h00, 1'b0, 1'b1);
        chk("err_busy", 32'(BUSY_O), 32'h0);
        repeat (20) @(negedge CLK_I);
        chk("err_no_bus", 32'(bus_rises - rises0), 32'h0);
        chk("err_no_tx", 32'(tx_log.size()), 32'h0);

        // Error and valid together in ADDR: error wins.
        send_byte(8'h52, 1'b1, 1'b0);
        send_byte(8'h20, 1'b1, 1'b1);
        chk("errvld_busy", 32'(BUSY_O), 32'h0);

        // Inter-byte gap: still waiting after 15 cycles, back to IDLE by the 17th.
        model_frame(48'h52, 1, 1'b0, 1, 32'h0);
        send_byte(8'h52, 1'b1, 1'b0);
        repeat (15) @(negedge CLK_I);
        chk("gap_busy_before", 32'(BUSY_O), 32'h1);
        repeat (2) @(negedge CLK_I);
        chk("gap_busy_after", 32'(BUSY_O), 32'h0);
        chk("gap_no_bus", 32'(bus_rises - rises0), 32'h0);
        chk("gap_no_tx", 32'(tx_log.size()), 32'h0);

        // Read with no ack: request for TIMEOUT cycles, reply 0x45, late ack ignored.
        run_frame(48'h52_30, 2, 0, 32'h0, 8'h00);
        chk("tmo_len", 32'(last_len), 32'd16);
        chk("tmo_reply_count", 32'(tx_log.size()), 32'd1);
        if (tx_log.size() == 1) chk("tmo_reply", 32'(tx_log[0]), 32'h45);

        // Reset while the read request is outstanding.
        tx_log.delete();
        ack_delay = 0;
        rises0 = bus_rises;
        model_frame(48'h52_40, 2, 1'b0, 0, 32'h0);
        send_byte(8'h52, 1'b1, 1'b0);
        send_byte(8'h40, 1'b1, 1'b0);
        chk("rst_bus_pre_re", 32'(BUS_RE_O), 32'h1);
        repeat (3) @(negedge CLK_I);
        #2 RESET_N_I = 1'b0;
        #1;
        chk("rst_bus_re", 32'(BUS_RE_O), 32'h0);
        chk("rst_bus_busy", 32'(BUSY_O), 32'h0);
        chk("rst_bus_addr", 32'(BUS_ADDR_O), 32'h0);
        exp_bus.delete();
        exp_tx.delete();
        @(negedge CLK_I);
        #2 RESET_N_I = 1'b1;
        repeat (40) @(negedge CLK_I);
        chk("rst_bus_no_tx", 32'(tx_log.size()), 32'h0);
        chk("rst_bus_one_req", 32'(bus_rises - rises0), 32'h1);
        chk("rst_bus_idle", 32'(BUSY_O), 32'h0);

        // Normal operation after reset.
        run_frame(48'h52_55, 2, 1, 32'hA1B2C3D4, 8'h00);
        chk("post_rst_count", 32'(tx_log.size()), 32'd4);
        if (tx_log.size() == 4) chk("post_rst_first", 32'(tx_log[0]), 32'hA1);

        repeat (5) @(negedge CLK_I);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
